// File: rtl/minirisc_pkg.sv
// Shared constants, opcode encoding and flag layout for the minirisc accumulator core.
package minirisc_pkg;

  localparam int DATA_W = 8;
  localparam int NREGS  = 4;
  localparam int OPC_W  = 4;
  localparam int SEL_W  = $clog2(NREGS);

  typedef enum logic [OPC_W-1:0] {
    OP_NOP   = 4'd0,
    OP_LOAD  = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_STORE = 4'd4,
    OP_LDR   = 4'd5,
    OP_ADDR  = 4'd6,
    OP_SUBR  = 4'd7,
    OP_AND   = 4'd8,
    OP_OR    = 4'd9,
    OP_XOR   = 4'd10,
    OP_SHL   = 4'd11,
    OP_SHR   = 4'd12,
    OP_STAT  = 4'd13,
    OP_CLR   = 4'd14,
    OP_RSVD  = 4'd15
  } opc_e;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

  // Opcodes that turn the uio bus around for the following cycle.
  function automatic logic drives_bus(opc_e op);
    return (op == OP_STORE) || (op == OP_STAT);
  endfunction

endpackage

// File: rtl/minirisc_alu.sv
// Combinational ALU: computes the new accumulator and flags for ACC-writing opcodes.
// Logic/shift opcodes (AND/OR/XOR/SHL/SHR) are only decoded when MINIRISC_LOGIC_EN is defined.
module minirisc_alu
  import minirisc_pkg::*;
(
  input  opc_e              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c,
  output logic              wr_acc
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // The ninth bit of the difference is set exactly when a < b (borrow).
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = a;
    c      = c_in;
    wr_acc = 1'b1;
    case (op)
      OP_LOAD, OP_LDR: result = b;
      OP_ADD, OP_ADDR: begin
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      OP_SUB, OP_SUBR: begin
        result = diff[DATA_W-1:0];
        c      = diff[DATA_W];
      end
`ifdef MINIRISC_LOGIC_EN
      OP_AND: begin
        result = a & b;
        c      = 1'b0;
      end
      OP_OR: begin
        result = a | b;
        c      = 1'b0;
      end
      OP_XOR: begin
        result = a ^ b;
        c      = 1'b0;
      end
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        c      = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        c      = a[0];
      end
`endif
      OP_CLR: begin
        result = '0;
        c      = 1'b0;
      end
      default: wr_acc = 1'b0;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/minirisc.sv
// Tiny Tapeout style 8-bit accumulator processor, one instruction per enabled clock.
// Optional logic/shift opcodes are enabled by defining MINIRISC_LOGIC_EN.
module minirisc
  import minirisc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [7:0]        ui_in,
  input  logic [7:0]        uio_in,
  output logic [DATA_W-1:0] uo_out,
  output logic [DATA_W-1:0] uio_out,
  output logic [DATA_W-1:0] uio_oe
);

  opc_e              op;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] regs [NREGS];
  flags_t            flags;

  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_z;
  logic              alu_c;
  logic              alu_wr;
  logic              unused_bits;

  assign op          = opc_e'(ui_in[OPC_W-1:0]);
  assign sel         = ui_in[OPC_W+SEL_W-1:OPC_W];
  assign unused_bits = ^ui_in[7:OPC_W+SEL_W];

  // Register-operand opcodes take R[SEL]; everything else uses the immediate.
  assign alu_b = (op inside {OP_LDR, OP_ADDR, OP_SUBR}) ? regs[sel] : uio_in;

  minirisc_alu u_alu (
    .op     (op),
    .a      (acc),
    .b      (alu_b),
    .c_in   (flags.c),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c),
    .wr_acc (alu_wr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      flags   <= '0;
      uio_out <= '0;
      uio_oe  <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (ena) begin
      uio_oe <= drives_bus(op) ? '1 : '0;
      if (op == OP_STORE) begin
        regs[sel] <= acc;
        uio_out   <= acc;
      end
      if (op == OP_STAT) uio_out <= {{(DATA_W-2){1'b0}}, flags.c, flags.z};
      if (alu_wr) begin
        acc     <= alu_result;
        flags.c <= alu_c;
        flags.z <= alu_z;
      end
    end
  end

  assign uo_out = acc;

endmodule

// File: tb/tb_minirisc.sv
// Self-checking bench for minirisc: directed vector table plus randomized programs vs. a reference model.
module tb_minirisc;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q[$];

  minirisc dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       ena;
    logic [3:0] op;
    logic [1:0] sel;
    logic [7:0] imm;
    logic [7:0] acc;
    logic [7:0] oe;
    logic [7:0] out;
  } vec_t;

  vec_t vecs[$];

`ifdef MINIRISC_LOGIC_EN
  localparam logic [7:0] SHL_ACC  = 8'h02;
  localparam logic [7:0] STAT_OUT = 8'h02;
`else
  localparam logic [7:0] SHL_ACC  = 8'h81;
  localparam logic [7:0] STAT_OUT = 8'h00;
`endif

  function automatic vec_t mk(logic r, logic e, logic [3:0] op, logic [1:0] sel, logic [7:0] imm,
                              logic [7:0] acc, logic [7:0] oe, logic [7:0] out);
    vec_t v;
    v.rst = r; v.ena = e; v.op = op; v.sel = sel; v.imm = imm;
    v.acc = acc; v.oe = oe; v.out = out;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int m_acc, m_c, m_z, m_out, m_oe;
  int m_regs[4];

  function automatic void model_reset();
    m_acc = 0; m_c = 0; m_z = 0; m_out = 0; m_oe = 0;
    foreach (m_regs[i]) m_regs[i] = 0;
  endfunction

  function automatic void set_acc(int v);
    m_acc = v;
    m_z   = (v == 0) ? 1 : 0;
  endfunction

  function automatic void model_step(bit r, bit e, int op, int sel, int imm);
    int operand;
    if (r) begin
      model_reset();
      return;
    end
    if (!e) return;
    m_oe    = (op == 4 || op == 13) ? 255 : 0;
    operand = (op == 5 || op == 6 || op == 7) ? m_regs[sel] : imm;
    case (op)
      1, 5: set_acc(operand);
      2, 6: begin
        m_c = (m_acc + operand > 255) ? 1 : 0;
        set_acc((m_acc + operand) % 256);
      end
      3, 7: begin
        m_c = (m_acc < operand) ? 1 : 0;
        set_acc((m_acc - operand + 256) % 256);
      end
      4: begin
        m_regs[sel] = m_acc;
        m_out       = m_acc;
      end
`ifdef MINIRISC_LOGIC_EN
      8:  begin m_c = 0; set_acc(m_acc & imm); end
      9:  begin m_c = 0; set_acc(m_acc | imm); end
      10: begin m_c = 0; set_acc(m_acc ^ imm); end
      11: begin m_c = m_acc / 128; set_acc((m_acc * 2) % 256); end
      12: begin m_c = m_acc % 2;   set_acc(m_acc / 2); end
`endif
      13: m_out = m_c * 2 + m_z;
      14: begin m_c = 0; set_acc(0); end
      default: ;
    endcase
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic drive(input logic r, input logic e, input logic [3:0] op,
                       input logic [1:0] sel, input logic [7:0] imm, input logic [1:0] junk);
    rst    = r;
    ena    = e;
    ui_in  = {junk, sel, op};
    uio_in = imm;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_scoreboard(input int step);
    logic [23:0] e;
    string tag;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1 at step %0d", step);
      return;
    end
    e = exp_q.pop_front();
    tag = $sformatf("rand%0d", step);
    check({tag, "_acc"},  uo_out,  e[23:16]);
    check({tag, "_oe"},   uio_oe,  e[15:8]);
    check({tag, "_out"},  uio_out, e[7:0]);
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b1; ena = 1'b0; ui_in = '0; uio_in = '0;

    vecs.push_back(mk(1, 1, 4'd0,  2'd0, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 4'd1,  2'd0, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 4'd2,  2'd0, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 4'd3,  2'd0, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 4'd4,  2'd0, 8'h00, 8'h00, 8'hFF, 8'h00));
    vecs.push_back(mk(0, 1, 4'd0,  2'd0, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 4'd1,  2'd0, 8'hF0, 8'hF0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 4'd2,  2'd0, 8'h20, 8'h10, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 4'd13, 2'd0, 8'h00, 8'h10, 8'hFF, 8'h02));
    vecs.push_back(mk(0, 1, 4'd0,  2'd0, 8'h00, 8'h10, 8'h00, 8'h02));
    vecs.push_back(mk(0, 1, 4'd1,  2'd0, 8'h05, 8'h05, 8'h00, 8'h02));
    vecs.push_back(mk(0, 1, 4'd3,  2'd0, 8'h05, 8'h00, 8'h00, 8'h02));
    vecs.push_back(mk(0, 1, 4'd13, 2'd0, 8'h00, 8'h00, 8'hFF, 8'h01));
    vecs.push_back(mk(0, 1, 4'd3,  2'd0, 8'h01, 8'hFF, 8'h00, 8'h01));
    vecs.push_back(mk(0, 1, 4'd13, 2'd0, 8'h00, 8'hFF, 8'hFF, 8'h02));
    vecs.push_back(mk(0, 1, 4'd1,  2'd0, 8'h3C, 8'h3C, 8'h00, 8'h02));
    vecs.push_back(mk(0, 1, 4'd4,  2'd2, 8'h00, 8'h3C, 8'hFF, 8'h3C));
    vecs.push_back(mk(0, 1, 4'd14, 2'd0, 8'h00, 8'h00, 8'h00, 8'h3C));
    vecs.push_back(mk(0, 1, 4'd5,  2'd2, 8'h00, 8'h3C, 8'h00, 8'h3C));
    vecs.push_back(mk(0, 1, 4'd6,  2'd2, 8'h00, 8'h78, 8'h00, 8'h3C));
    vecs.push_back(mk(0, 1, 4'd4,  2'd1, 8'h00, 8'h78, 8'hFF, 8'h78));
    vecs.push_back(mk(0, 1, 4'd13, 2'd0, 8'h00, 8'h78, 8'hFF, 8'h00));
    vecs.push_back(mk(0, 1, 4'd1,  2'd0, 8'h81, 8'h81, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 4'd11, 2'd0, 8'h00, SHL_ACC, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 4'd13, 2'd0, 8'h00, SHL_ACC, 8'hFF, STAT_OUT));
    vecs.push_back(mk(0, 0, 4'd1,  2'd0, 8'h55, SHL_ACC, 8'hFF, STAT_OUT));
    vecs.push_back(mk(0, 0, 4'd4,  2'd3, 8'h00, SHL_ACC, 8'hFF, STAT_OUT));
    vecs.push_back(mk(0, 1, 4'd1,  2'd0, 8'h55, 8'h55, 8'h00, STAT_OUT));
    vecs.push_back(mk(0, 1, 4'd5,  2'd1, 8'h00, 8'h78, 8'h00, STAT_OUT));
    vecs.push_back(mk(0, 1, 4'd5,  2'd3, 8'h00, 8'h00, 8'h00, STAT_OUT));
    vecs.push_back(mk(0, 1, 4'd4,  2'd0, 8'h00, 8'h00, 8'hFF, 8'h00));
    vecs.push_back(mk(1, 1, 4'd1,  2'd0, 8'h77, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 4'd5,  2'd2, 8'h00, 8'h00, 8'h00, 8'h00));

    drive(1'b1, 1'b0, 4'd0, 2'd0, 8'h00, 2'd0);
    drive(1'b1, 1'b0, 4'd0, 2'd0, 8'h00, 2'd0);
    check("reset_acc", uo_out,  8'h00);
    check("reset_oe",  uio_oe,  8'h00);
    check("reset_out", uio_out, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ena, vecs[i].op, vecs[i].sel, vecs[i].imm, 2'(i));
      check($sformatf("vec%0d_acc", i), uo_out,  vecs[i].acc);
      check($sformatf("vec%0d_oe",  i), uio_oe,  vecs[i].oe);
      check($sformatf("vec%0d_out", i), uio_out, vecs[i].out);
    end

    // Randomized programs against the reference model, starting from reset.
    model_reset();
    drive(1'b1, 1'b1, 4'd0, 2'd0, 8'h00, 2'd0);
    for (int n = 0; n < 600; n++) begin
      logic       r, e;
      logic [3:0] op;
      logic [1:0] sel;
      logic [7:0] imm;
      r   = ($urandom_range(99) < 3);
      e   = ($urandom_range(99) < 88);
      op  = 4'($urandom_range(15));
      sel = 2'($urandom_range(3));
      imm = ($urandom_range(3) == 0) ? 8'($urandom_range(1) * 255) : 8'($urandom_range(255));
      model_step(r, e, int'(op), int'(sel), int'(imm));
      exp_q.push_back({8'(m_acc), 8'(m_oe), 8'(m_out)});
      drive(r, e, op, sel, imm, 2'($urandom_range(3)));
      check_scoreboard(n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
